// File: rtl/gcd_requester_if.sv
// rtl/gcd_requester_if.sv - client and engine handshake signals for the GCD requester
interface gcd_requester_if;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_ready;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        done;
    logic [15:0] gcd;
    logic        out_valid;
    logic [15:0] out_gcd;
    logic        out_err;
    logic        out_ready;

    modport slave (
        input  in_valid, in_a, in_b, done, gcd, out_ready,
        output in_ready, start, a, b, out_valid, out_gcd, out_err
    );

    modport master (
        output in_valid, in_a, in_b, done, gcd, out_ready,
        input  in_ready, start, a, b, out_valid, out_gcd, out_err
    );
endinterface

// File: rtl/gcd_requester.sv
// rtl/gcd_requester.sv - issues one job to a GCD engine and returns its result or a timeout
module gcd_requester #(
    parameter logic [16:0] TIMEOUT = 17'd70000
) (
    input logic            clk,
    input logic            rst_n,
    gcd_requester_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, DRAIN, RESP} state_t;

    state_t      state_q, state_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        start_q, start_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_gcd_q, out_gcd_d;
    logic        out_err_q, out_err_d;
    logic [16:0] cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        a_d         = a_q;
        b_d         = b_q;
        start_d     = 1'b0;
        out_valid_d = out_valid_q;
        out_gcd_d   = out_gcd_q;
        out_err_d   = out_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_a_d  = bus.in_a;
                    op_b_d  = bus.in_b;
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 17'd0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.done) begin
                    out_gcd_d = bus.gcd;
                    out_err_d = 1'b0;
                    state_d   = DRAIN;
                end else begin
                    cnt_d = cnt_q + 17'd1;
                    if (cnt_d == TIMEOUT) begin
                        out_gcd_d   = 16'd0;
                        out_err_d   = 1'b1;
                        out_valid_d = 1'b1;
                        a_d         = 16'd0;
                        b_d         = 16'd0;
                        state_d     = RESP;
                    end
                end
            end
            // The engine holds done for two cycles; wait it out so the
            // second cycle is neither recaptured nor overlapped by a new start.
            DRAIN: begin
                if (!bus.done) begin
                    out_valid_d = 1'b1;
                    a_d         = 16'd0;
                    b_d         = 16'd0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= 16'd0;
            op_b_q      <= 16'd0;
            a_q         <= 16'd0;
            b_q         <= 16'd0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_gcd_q   <= 16'd0;
            out_err_q   <= 1'b0;
            cnt_q       <= 17'd0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            a_q         <= a_d;
            b_q         <= b_d;
            start_q     <= start_d;
            out_valid_q <= out_valid_d;
            out_gcd_q   <= out_gcd_d;
            out_err_q   <= out_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.start     = start_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_gcd   = out_gcd_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_gcd_requester.sv
// tb/tb_gcd_requester.sv - directed bench for gcd_requester with a behavioural GCD engine
module tb_gcd_requester;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcd_requester_if ifc ();
    gcd_requester #(.TIMEOUT(17'd20)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int checks = 0;
    int errors = 0;
    bit eng_en = 1'b1;
    int eng_lat = 2;
    int start_cnt = 0;
    logic [15:0] eng_r;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        logic        err;
        int          lat;
    } vec_t;
    vec_t vecs[5];

    logic [15:0] bb_a[3];
    logic [15:0] bb_b[3];
    logic [15:0] bb_g[3];

    function automatic logic [15:0] ref_gcd(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] t;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) if (ifc.start) start_cnt++;

    // Engine: answers each start after eng_lat cycles with done held for two cycles.
    initial begin
        ifc.done = 1'b0;
        ifc.gcd  = 16'd0;
        forever begin
            @(posedge clk);
            #2;
            if (ifc.start && eng_en) begin
                eng_r = ref_gcd(ifc.a, ifc.b);
                repeat (eng_lat) @(posedge clk);
                #2;
                ifc.done = 1'b1;
                ifc.gcd  = eng_r;
                @(posedge clk);
                @(posedge clk);
                #2;
                ifc.done = 1'b0;
                ifc.gcd  = 16'd0;
            end
        end
    end

    task automatic run_job(input logic [15:0] x, input logic [15:0] y, input logic [15:0] eg,
                           input logic eerr, input int exp_lat, input string tag);
        int  k;
        int  s0;
        bit  hold_ok;
        s0 = start_cnt;
        hold_ok = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_a = x;
        ifc.in_b = y;
        tick();
        ifc.in_valid = 1'b0;
        chk({tag, "_start"}, 32'(ifc.start), 32'd1);
        chk({tag, "_issue_ops"}, {ifc.a, ifc.b}, {x, y});
        k = 0;
        while (!ifc.out_valid && k < 100) begin
            tick();
            k++;
            if (!ifc.out_valid && {ifc.a, ifc.b} != {x, y}) hold_ok = 1'b0;
        end
        chk({tag, "_resp_seen"}, 32'(ifc.out_valid), 32'd1);
        chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_ops_held"}, 32'(hold_ok), 32'd1);
        chk({tag, "_out_gcd"}, 32'(ifc.out_gcd), 32'(eg));
        chk({tag, "_out_err"}, 32'(ifc.out_err), 32'(eerr));
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk({tag, "_released"}, {30'd0, ifc.out_valid, ifc.in_ready}, 32'd1);
        chk({tag, "_one_start"}, start_cnt - s0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int  s0;
        int  cyc;
        int  idx;
        int  nresp;
        int  last_resp_cyc;
        bit  sep_ok;
        bit  prev_done;
        bit  quiet;

        vecs[0] = '{16'd48,    16'd18,    16'd6,     1'b0, 5};
        vecs[1] = '{16'd0,     16'd7,     16'd7,     1'b0, 5};
        vecs[2] = '{16'd0,     16'd0,     16'd0,     1'b0, 5};
        vecs[3] = '{16'd100,   16'd75,    16'd25,    1'b0, 5};
        vecs[4] = '{16'd65535, 16'd65535, 16'd65535, 1'b0, 5};
        bb_a = '{16'd12, 16'd65535, 16'd9};
        bb_b = '{16'd8,  16'd1,     16'd9};
        bb_g = '{16'd4,  16'd1,     16'd9};

        ifc.in_valid  = 1'b0;
        ifc.in_a      = 16'd0;
        ifc.in_b      = 16'd0;
        ifc.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_start", 32'(ifc.start), 32'd0);
        chk("reset_ab", {ifc.a, ifc.b}, 32'd0);
        chk("reset_out", {14'd0, ifc.out_valid, ifc.out_gcd, ifc.out_err}, 32'd0);
        chk("reset_in_ready", 32'(ifc.in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++)
            run_job(vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].err, vecs[i].lat, $sformatf("vec%0d", i));

        // Backpressure: response held for 5 cycles while a new request is offered.
        s0 = start_cnt;
        ifc.in_valid = 1'b1;
        ifc.in_a = 16'd30;
        ifc.in_b = 16'd12;
        tick();
        ifc.in_valid = 1'b0;
        cyc = 0;
        while (!ifc.out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("bp_resp_seen", 32'(ifc.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_a = 16'd9;
            ifc.in_b = 16'd3;
            tick();
            chk($sformatf("bp_hold%0d", i), {14'd0, ifc.out_valid, ifc.in_ready, ifc.out_gcd},
                {14'd0, 1'b1, 1'b0, 16'd6});
        end
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk("bp_release", {15'd0, ifc.out_valid, ifc.out_gcd}, {15'd0, 1'b0, 16'd6});
        chk("bp_no_extra_start", start_cnt - s0, 1);
        tick();

        // Timeout: engine silent, 20 WAIT_DONE cycles then error response.
        eng_en = 1'b0;
        run_job(16'd14, 16'd21, 16'd0, 1'b1, 21, "timeout");
        eng_en = 1'b1;
        tick();

        // Mid-job reset, with the engine answering after reset is released.
        eng_lat = 6;
        ifc.in_valid = 1'b1;
        ifc.in_a = 16'd20;
        ifc.in_b = 16'd8;
        tick();
        ifc.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_state", {28'd0, ifc.in_ready, ifc.start, ifc.out_valid, |ifc.a},
            {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        s0 = start_cnt;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ifc.out_valid || ifc.start || !ifc.in_ready) quiet = 1'b0;
        end
        chk("mrst_late_done_ignored", 32'(quiet), 32'd1);
        chk("mrst_no_start", start_cnt - s0, 0);
        eng_lat = 2;
        run_job(16'd35, 16'd21, 16'd7, 1'b0, 5, "post_reset");

        // Back-to-back jobs with in_valid and out_ready held high.
        s0 = start_cnt;
        ifc.out_ready = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_a = bb_a[0];
        ifc.in_b = bb_b[0];
        idx = 0;
        nresp = 0;
        cyc = 0;
        last_resp_cyc = 0;
        sep_ok = 1'b1;
        prev_done = 1'b0;
        while (nresp < 3 && cyc < 300) begin
            tick();
            cyc++;
            if (ifc.start) begin
                if (ifc.done || prev_done) sep_ok = 1'b0;
                if (idx > 0) chk($sformatf("b2b_gap%0d", idx), cyc - last_resp_cyc, 2);
                idx++;
                if (idx < 3) begin
                    ifc.in_a = bb_a[idx];
                    ifc.in_b = bb_b[idx];
                end else begin
                    ifc.in_valid = 1'b0;
                end
            end
            if (ifc.out_valid) begin
                chk($sformatf("b2b_resp%0d", nresp), {15'd0, ifc.out_err, ifc.out_gcd},
                    {15'd0, 1'b0, bb_g[nresp]});
                nresp++;
                last_resp_cyc = cyc;
            end
            prev_done = ifc.done;
        end
        ifc.in_valid = 1'b0;
        tick();
        ifc.out_ready = 1'b0;
        chk("b2b_resp_count", nresp, 3);
        chk("b2b_start_count", start_cnt - s0, 3);
        chk("b2b_start_after_done", 32'(sep_ok), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gcd_requester.md
GCD_REQUESTER -- requirements
Module: gcd_requester

Interface
REQ-001 Parameter TIMEOUT, default 17'd70000: maximum number of cycles spent in WAIT_DONE before the request is abandoned.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  client request present.
REQ-005 in_a, in_b  input  16 each  client operands.
REQ-006 in_ready  output  1  requester can accept a request.
REQ-007 start  output  1  one-cycle request pulse to the GCD engine.
REQ-008 a, b  output  16 each  operands driven to the engine.
REQ-009 done  input  1  engine result-valid; high for 2 consecutive cycles per job.
REQ-010 gcd  input  16  engine result; valid while done=1.
REQ-011 out_valid  output  1  response available to the client.
REQ-012 out_gcd  output  16  captured result (0 on timeout).
REQ-013 out_err  output  1  1 = response produced by timeout.
REQ-014 out_ready  input  1  client accepts the response.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE, DRAIN and RESP; state and every output register SHALL update only on the rising clk edge.
REQ-016 IDLE: in_ready=1; on in_valid=1 the block SHALL register in_a and in_b into op_a and op_b, then move to ISSUE.
REQ-017 ISSUE (exactly 1 cycle): start=1, a=op_a, b=op_b; the next state SHALL be WAIT_DONE.
REQ-018 a and b SHALL equal op_a and op_b from ISSUE until DRAIN is exited, and SHALL be 0 in IDLE.
REQ-019 WAIT_DONE: on done=1 the block SHALL capture gcd into out_gcd, clear out_err, then move to DRAIN.
REQ-020 WAIT_DONE: a 17-bit counter cleared on entry SHALL increment each cycle that done=0.
  - When the counter reaches TIMEOUT: out_gcd=0, out_err=1, next state RESP (DRAIN is skipped).
REQ-021 DRAIN: the block SHALL remain in DRAIN while done=1 and move to RESP on the first cycle with done=0.
  - The second done cycle SHALL NOT be captured twice.
  - No new start SHALL be issued while done is high.
REQ-022 RESP: out_valid=1 with stable out_gcd and out_err; on out_ready=1 the next state SHALL be IDLE.
  - out_valid deasserts the following cycle; out_gcd and out_err hold their values until the next capture.
REQ-023 in_ready SHALL be 1 only in IDLE; in_valid in any other state SHALL be ignored with no buffering.
REQ-024 start SHALL be 0 in every state except ISSUE.
REQ-025 Latency SHALL be fixed as follows.
  - Request accepted at edge N -> start high in cycle N+1.
  - done first high at edge M -> out_valid high at edge M+2, given done drops after 2 cycles.
REQ-026 Operands a=0 or b=0 SHALL be forwarded unchanged; the engine's result (including 0) is reported with out_err=0.
REQ-027 done=1 while in IDLE, ISSUE or RESP SHALL be ignored.
REQ-028 With out_ready held at 1 and in_valid held at 1, back-to-back jobs SHALL be processed, with IDLE occupying one cycle between them.

Reset
REQ-029 While rst_n=0 at a clock edge, the block SHALL enter IDLE with the following values.
  - start=0, a=0, b=0, out_valid=0, out_gcd=0, out_err=0.
  - Timeout counter=0, op_a=0, op_b=0.
REQ-030 Reset applied in any state, including mid-job, SHALL abort the job with no response.
  - A done pulse arriving after reset is released SHALL be ignored, per REQ-027.

Verification
REQ-031 Basic job: in a=48, b=18, engine model returns gcd=6 with done for 2 cycles.
  - Exactly one start pulse; a=48, b=18 held until DRAIN exits.
  - out_valid with out_gcd=6, out_err=0.
REQ-032 Backpressure: out_ready=0 for 5 cycles in RESP.
  - out_valid and out_gcd stay stable; in_ready=0 throughout; a new in_valid is not accepted.
REQ-033 Timeout: TIMEOUT overridden to 17'd20, engine never asserts done.
  - After 20 WAIT_DONE cycles: out_valid=1, out_gcd=0, out_err=1; the block then returns to IDLE.
REQ-034 Zero operands: a=0, b=7 with engine returning 7 -> out_gcd=7, out_err=0.
  - a=0, b=0 with engine returning 0 -> out_gcd=0, out_err=0.
REQ-035 Mid-job reset: rst_n=0 for 1 cycle during WAIT_DONE, followed by a late done pulse.
  - No out_valid; start=0; in_ready=1 after reset.
  - The next job (35, 21 -> 7) completes normally.
REQ-036 Back-to-back: three queued jobs (12,8)->4, (65535,1)->1, (9,9)->9 with out_ready=1.
  - Three responses in order; exactly three start pulses, each separated from the previous done by at least 1 cycle.
